// File: rtl/ccb_cmd_decoder.sv
// CCB command/data bus decoder: registers and inverts the active-low CCB lines, decodes
// commands on strobe rising edges and runs a timed command-plus-data load window.
`timescale 1ns/1ps
module ccb_cmd_decoder #(
    parameter int         NCAL     = 3,
    parameter logic [5:0] CAL_BASE = 6'h14,
    parameter int         SRST_LEN = 16,
    parameter logic [5:0] DATA_CMD = 6'h20,
    parameter int         DATA_TMO = 8,
    parameter int         CNT_W    = 8
) (
    input  logic             CLKCMS,
    input  logic             RSTN,
    input  logic             CLKENAIN,
    input  logic             L1ARSTIN,
    input  logic             BXRSTIN,
    input  logic             BX0IN,
    input  logic             CMDSTRB,
    input  logic             DATASTRB,
    input  logic [5:0]       CCBCMD,
    input  logic [7:0]       CCBDATA,
    output logic             CLKENA,
    output logic             BX0,
    output logic             BXRST,
    output logic             L1ARST,
    output logic             BC0,
    output logic             L1ASRST,
    output logic             TRG_EN,
    output logic [NCAL-1:0]  TTCCAL,
    output logic             RSTDATA,
    output logic             DATA_VLD,
    output logic [7:0]       DATA_OUT,
    output logic             DATA_TMO_ERR,
    output logic [CNT_W-1:0] CMD_CNT
);

    localparam int SRST_W = $clog2(SRST_LEN + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    logic              cmd_strb_s, data_strb_s;
    logic              cmd_strb_p, data_strb_p;
    logic [5:0]        cmd_s;
    logic [7:0]        data_s;
    logic              cmd_edge, data_edge;
    logic [SRST_W-1:0] srst_cnt;
    logic [NCAL-1:0]   cal_hit;
    state_t            state_q, state_d;
    logic [7:0]        timer_q, timer_d;
    logic [7:0]        dout_d;
    logic              vld_d, err_d;

    // Input stage: every CCB line is captured inverted, so everything downstream is active-high.
    always_ff @(posedge CLKCMS or negedge RSTN) begin
        if (!RSTN) begin
            CLKENA      <= 1'b0;
            BX0         <= 1'b0;
            BXRST       <= 1'b0;
            L1ARST      <= 1'b0;
            cmd_strb_s  <= 1'b0;
            data_strb_s <= 1'b0;
            cmd_s       <= '0;
            data_s      <= '0;
            cmd_strb_p  <= 1'b0;
            data_strb_p <= 1'b0;
        end else begin
            CLKENA      <= ~CLKENAIN;
            BX0         <= ~BX0IN;
            BXRST       <= ~BXRSTIN;
            L1ARST      <= ~L1ARSTIN;
            cmd_strb_s  <= ~CMDSTRB;
            data_strb_s <= ~DATASTRB;
            cmd_s       <= ~CCBCMD;
            data_s      <= ~CCBDATA;
            cmd_strb_p  <= cmd_strb_s;
            data_strb_p <= data_strb_s;
        end
    end

    assign cmd_edge  = cmd_strb_s & ~cmd_strb_p;
    assign data_edge = data_strb_s & ~data_strb_p;

    always_comb begin
        cal_hit = '0;
        for (int i = 0; i < NCAL; i++) begin
            if (cmd_edge && (cmd_s == CAL_BASE + 6'(i))) cal_hit[i] = 1'b1;
        end
    end

    always_ff @(posedge CLKCMS or negedge RSTN) begin
        if (!RSTN) begin
            BC0      <= 1'b0;
            TTCCAL   <= '0;
            TRG_EN   <= 1'b0;
            RSTDATA  <= 1'b0;
            CMD_CNT  <= '0;
            srst_cnt <= '0;
        end else begin
            BC0     <= cmd_edge && (cmd_s == 6'h01);
            TTCCAL  <= cal_hit;
            RSTDATA <= data_edge && (data_s[7:1] == 7'h2A);
            if (cmd_edge && (cmd_s == 6'h06)) TRG_EN <= 1'b1;
            else if (cmd_edge && (cmd_s == 6'h07)) TRG_EN <= 1'b0;
            // The soft-reset command also clears the counter and is not counted itself.
            if (cmd_edge) begin
                if (cmd_s == 6'h03) CMD_CNT <= '0;
                else if (CMD_CNT != '1) CMD_CNT <= CMD_CNT + CNT_W'(1);
            end
            if (cmd_edge && (cmd_s == 6'h03)) srst_cnt <= SRST_W'(SRST_LEN);
            else if (srst_cnt != '0) srst_cnt <= srst_cnt - SRST_W'(1);
        end
    end

    assign L1ASRST = (srst_cnt != '0);

    // Data-load window: data beats a reload, a reload beats the timeout.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dout_d  = DATA_OUT;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_edge && (cmd_s == DATA_CMD)) begin
                    state_d = ST_WAIT;
                    timer_d = 8'(DATA_TMO);
                end
            end
            ST_WAIT: begin
                if (data_edge) begin
                    dout_d  = data_s;
                    vld_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cmd_edge && (cmd_s == DATA_CMD)) begin
                    timer_d = 8'(DATA_TMO);
                end else if (timer_q == 8'd1) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLKCMS or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            DATA_OUT     <= '0;
            DATA_VLD     <= 1'b0;
            DATA_TMO_ERR <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            DATA_OUT     <= dout_d;
            DATA_VLD     <= vld_d;
            DATA_TMO_ERR <= err_d;
        end
    end

endmodule

// File: doc/ccb_cmd_decoder.md
Name: ccb_cmd_decoder

Overview:
- Parametrised next-generation decoder for the active-low CCB command/data bus and the CCB fast-control lines.
- Registers and inverts the CCB inputs, then decodes commands on the rising edge of each strobe only.
- Generates BC0, a stretched L1A soft reset, a trigger-enable level, NCAL calibration pulses and a command-plus-data load channel with timeout.
- Sits between the CCB connector IOBs and the DMB control logic.

Parameters:
- NCAL, 3, number of TTC calibration outputs (1..8); codes CAL_BASE .. CAL_BASE+NCAL-1.
- CAL_BASE, 6'h14, first calibration command code.
- SRST_LEN, 16, L1ASRST pulse length in clocks (2..256).
- DATA_CMD, 6'h20, command that opens a data-load window.
- DATA_TMO, 8, window length in clocks (1..255).
- CNT_W, 8, width of the command counter.

Ports:
- CLKCMS  in  1  40 MHz CMS clock; all logic on its rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- CLKENAIN, L1ARSTIN, BXRSTIN, BX0IN  in  1 each  CCB fast lines, active low.
- CMDSTRB  in  1  command strobe, active low.
- DATASTRB  in  1  data strobe, active low.
- CCBCMD  in  6  command code, active low.
- CCBDATA  in  8  data byte, active low.
- CLKENA, BX0, BXRST, L1ARST  out  1 each  registered, active-high copies of the fast lines.
- BC0  out  1  one-clock pulse on command 6'h01.
- L1ASRST  out  1  SRST_LEN-clock pulse on command 6'h03.
- TRG_EN  out  1  level; set by 6'h06, cleared by 6'h07.
- TTCCAL  out  NCAL  one-clock pulse per calibration code.
- RSTDATA  out  1  one-clock pulse on data byte 8'h54 or 8'h55.
- DATA_VLD  out  1  one-clock pulse; DATA_OUT valid.
- DATA_OUT  out  8  last loaded data byte, held.
- DATA_TMO_ERR  out  1  one-clock pulse when the data window expires.
- CMD_CNT  out  CNT_W  count of decoded command strobes, saturating.

Behaviour:
- Reset (RSTN low, asynchronous): every output, the input registers, the edge-detect flops, the counters and the FSM go to 0/IDLE.
- Stage 1 (IOB): every input is registered inverted at edge k.
- Fast lines: CLKENA, BX0, BXRST and L1ARST equal the stage-1 values, so they are valid after edge k.
- Stage 2 (decode):
  - cmd_edge = stage-1 strobe high AND its previous value low. The same rule gives data_edge.
  - A strobe held low for N cycles is decoded once.
  - Decoded outputs are registered at edge k+1 and valid for the cycle after it.
- BC0, TTCCAL[i]: high for exactly one clock after cmd_edge with the matching code. Codes outside the active range are ignored; they are still counted.
- L1ASRST:
  - Goes high at decode and stays high exactly SRST_LEN clocks.
  - A new 6'h03 while active restarts the count, giving SRST_LEN clocks from the new command.
  - Length counter width is clog2(SRST_LEN+1).
- TRG_EN: 6'h06 sets it; 6'h07 clears it. Repeated commands have no further effect.
- CMD_CNT:
  - Increments on every cmd_edge and saturates at all-ones.
  - Command 6'h03 clears it to 0 and is not itself counted.
- RSTDATA: one-clock pulse on data_edge with byte 8'h54 or 8'h55, in any FSM state.
- Data FSM, states IDLE and WAIT:
  - IDLE to WAIT on cmd_edge with DATA_CMD; the timer loads DATA_TMO.
  - In WAIT, the timer decrements each clock.
  - In WAIT, data_edge captures the byte into DATA_OUT, pulses DATA_VLD for 1 clock and returns to IDLE.
  - In WAIT, a timer of 1 with no data_edge pulses DATA_TMO_ERR and returns to IDLE. The window is therefore exactly DATA_TMO clocks after entry.
  - A DATA_CMD in WAIT reloads the timer and stays in WAIT.
  - Any other command in WAIT is decoded normally and does not affect the FSM.
  - data_edge in IDLE leaves DATA_OUT unchanged.
  - Simultaneous cmd_edge(DATA_CMD) and data_edge in IDLE: enter WAIT; the data is not consumed.
  - Simultaneous data_edge and timeout: the data wins (DATA_VLD, no error).
- Reset mid-operation: L1ASRST drops immediately, the FSM returns to IDLE and DATA_OUT clears.

Test Plan:
- Reset, then hold CMDSTRB low for 5 clocks with CCBCMD=~6'h01 -> exactly one BC0 pulse, 2 edges after the first sampled edge; CMD_CNT=1.
- Command 6'h03 -> L1ASRST high for 16 clocks. A second 6'h03 at clock 10 -> high for 26 clocks total; CMD_CNT=0.
- Commands 6'h06, 6'h06, 6'h07 -> TRG_EN rises after the first and falls after the third. With NCAL=3, commands 6'h14/6'h15/6'h16/6'h17 -> TTCCAL pulses 001/010/100 and nothing for 6'h17.
- Command 6'h20, then DATASTRB with byte 8'hA5 three clocks later -> DATA_VLD pulse, DATA_OUT=8'hA5. A data strobe with 8'h54 in IDLE -> RSTDATA only; DATA_OUT unchanged.
- Command 6'h20 with no data -> DATA_TMO_ERR exactly 8 clocks after WAIT entry. Repeat with data on the 8th clock -> DATA_VLD and no error.
- CNT_W=4, send 20 commands -> CMD_CNT saturates at 4'hF. Assert RSTN mid-L1ASRST -> all outputs 0 asynchronously.
